// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use interlock, taken-branch flush and multi-cycle
// multiplier sequencing for the 5-stage RV32 pipeline.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating
// stall-cycle counter on stall_cycles_out (tied to zero otherwise).
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   RUN      | normal flow; branch flush, MUL issue, load-use stall
//   MUL_BUSY | multiplier owns EX; cnt counts remaining stall cycles,
//            | cnt == 0 is the release cycle
module hazard_ctrl #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_inst,
  input  logic [4:0]  id_ra_idx,
  input  logic [4:0]  id_rb_idx,
  input  logic        id_uses_ra,
  input  logic        id_uses_rb,
  input  logic        id_ex_valid_inst,
  input  logic        id_ex_rd_mem,
  input  logic        id_ex_is_mul,
  input  logic [4:0]  id_ex_dest_reg_idx,
  input  logic        ex_take_branch,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        mul_start,
  output logic [31:0] stall_cycles_out
);

  typedef enum logic [0:0] {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;

  // Issue cycle is the first stall cycle, so the busy phase holds
  // MUL_LATENCY-2 further stall cycles before the release cycle.
  localparam logic [3:0] CNT_INIT = (MUL_LATENCY >= 2) ? 4'(MUL_LATENCY - 2) : 4'd0;
  localparam bit         MUL_MULTI = (MUL_LATENCY > 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ld_use;
  logic       mul_issue;

  // Hazard detection terms; x0 never creates a dependency.
  always_comb begin
    ld_use = id_valid_inst & id_ex_valid_inst & id_ex_rd_mem &
             (id_ex_dest_reg_idx != 5'd0) &
             ((id_uses_ra & (id_ra_idx == id_ex_dest_reg_idx)) |
              (id_uses_rb & (id_rb_idx == id_ex_dest_reg_idx)));
    mul_issue = (state_q == RUN) & id_ex_valid_inst & id_ex_is_mul;
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mul_start     = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_take_branch) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (mul_issue) begin
          mul_start = 1'b1;
          if (MUL_MULTI) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = MUL_BUSY;
            cnt_d         = CNT_INIT;
          end
        end else if (ld_use) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_bubble = 1'b1;
        end
      end
      MUL_BUSY: begin
        if (cnt_q != 4'd0) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_bubble = 1'b1;
          cnt_d         = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= 32'd0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles_out = stall_cycles_q;
`else
  assign stall_cycles_out = 32'h0;
`endif

endmodule
